// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant FSM sharing one 2:1 data mux between two valid/ready sources
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din0_valid,
    input  logic [WIDTH-1:0] din0_data,
    output logic             din0_ready,
    input  logic             din1_valid,
    input  logic [WIDTH-1:0] din1_data,
    output logic             din1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic [8:0] MAX9 = 9'(MAX_BURST);
    localparam logic [7:0] MAX8 = 8'(MAX_BURST);
    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       own_v, oth_v;
    logic [1:0] oth_s;
    logic [8:0] cnt_inc;
    assign own_v   = (state_q == GNT1) ? din1_valid : din0_valid;
    assign oth_v   = (state_q == GNT1) ? din0_valid : din1_valid;
    assign oth_s   = (state_q == GNT1) ? GNT0 : GNT1;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    // state, last-served and burst counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
    // next-state arbitration: tie goes to the source not served last, burst cap forces a handover
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (din0_valid && (!din1_valid || last_q))
                    state_d = GNT0;
                else if (din1_valid)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (!own_v)
                    state_d = oth_v ? oth_s : IDLE;
                else if (out_ready) begin
                    if (cnt_inc >= MAX9 && oth_v)
                        state_d = oth_s;
                    else
                        cnt_d = (cnt_inc > MAX9) ? MAX8 : cnt_inc[7:0];
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q && state_d != IDLE) begin
            last_d = (state_d == GNT1);
            cnt_d  = '0;
        end
    end
    // mux select and handshake gating decoded from the registered state
    always_comb begin
        sel        = (state_q == GNT1);
        busy       = (state_q != IDLE);
        out_data   = sel ? din1_data : din0_data;
        out_valid  = (state_q == GNT0) ? din0_valid : (state_q == GNT1) ? din1_valid : 1'b0;
        din0_ready = (state_q == GNT0) && out_ready;
        din1_ready = (state_q == GNT1) && out_ready;
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: cycle-trace vector table plus directed stall, drop, idle and reset sequences
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n, din0_valid, din1_valid, out_ready;
    logic [7:0] din0_data, din1_data, out_data;
    logic       din0_ready, din1_ready, out_valid, sel, busy;
    int         n_pass = 0;
    int         n_tot  = 0;

    typedef struct packed {
        logic       rst_n;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .din0_valid(din0_valid), .din0_data(din0_data), .din0_ready(din0_ready),
        .din1_valid(din1_valid), .din1_data(din1_data), .din1_ready(din1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] fo(logic s, logic b, logic ov, logic r0, logic r1, logic [7:0] d);
        return {s, b, ov, r0, r1, d};
    endfunction

    task automatic add(logic r, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1, logic o, logic [12:0] e);
        tbl.push_back({r, v0, d0, v1, d1, o, e});
    endtask

    task automatic step(logic r, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1, logic o);
        @(posedge clk);
        #1;
        rst_n = r; din0_valid = v0; din0_data = d0; din1_valid = v1; din1_data = d1; out_ready = o;
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [12:0] e);
        logic [12:0] a;
        a = {sel, busy, out_valid, din0_ready, din1_ready, out_data};
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: {sel,busy,ov,r0,r1,data} got %b_%h need %b_%h", name, a[12:8], a[7:0], e[12:8], e[7:0]);
    endtask

    initial begin
        rst_n = 1'b0; din0_valid = 1'b0; din1_valid = 1'b0; out_ready = 1'b0;
        din0_data = 8'h00; din1_data = 8'h00;
        // single source stream, saturation then handover, drain
        add(0, 0, 8'h55, 0, 8'h66, 0, fo(0, 0, 0, 0, 0, 8'h55));
        add(1, 1, 8'h11, 0, 8'h00, 1, fo(0, 0, 0, 0, 0, 8'h11));
        for (int i = 0; i < 6; i++)
            add(1, 1, 8'(8'h11 + i), 0, 8'h00, 1, fo(0, 1, 1, 1, 0, 8'(8'h11 + i)));
        add(1, 1, 8'h17, 1, 8'hC0, 1, fo(0, 1, 1, 1, 0, 8'h17));
        add(1, 0, 8'h00, 1, 8'hC0, 1, fo(1, 1, 1, 0, 1, 8'hC0));
        add(1, 0, 8'h00, 0, 8'h00, 1, fo(1, 1, 0, 0, 1, 8'h00));
        // reset, then both streams alternate in bursts of four
        add(0, 0, 8'h00, 0, 8'h00, 0, fo(0, 0, 0, 0, 0, 8'h00));
        add(1, 1, 8'hA0, 1, 8'hB0, 1, fo(0, 0, 0, 0, 0, 8'hA0));
        for (int i = 0; i < 4; i++)
            add(1, 1, 8'(8'hA0 + i), 1, 8'hB0, 1, fo(0, 1, 1, 1, 0, 8'(8'hA0 + i)));
        for (int i = 0; i < 4; i++)
            add(1, 1, 8'hA4, 1, 8'(8'hB0 + i), 1, fo(1, 1, 1, 0, 1, 8'(8'hB0 + i)));
        add(1, 1, 8'hA4, 1, 8'hB4, 1, fo(0, 1, 1, 1, 0, 8'hA4));
        repeat (2) @(posedge clk);
        foreach (tbl[k]) begin
            step(tbl[k].rst_n, tbl[k].v0, tbl[k].d0, tbl[k].v1, tbl[k].d1, tbl[k].ordy);
            chk($sformatf("vec%0d", k), tbl[k].exp);
        end
        // finish the GNT0 burst, one GNT1 beat, then a 5-cycle stall
        for (int i = 5; i < 8; i++) begin
            step(1, 1, 8'(8'hA0 + i), 1, 8'hB4, 1);
            chk("burst0", fo(0, 1, 1, 1, 0, 8'(8'hA0 + i)));
        end
        step(1, 1, 8'hA8, 1, 8'hB4, 1);
        chk("gnt1_first", fo(1, 1, 1, 0, 1, 8'hB4));
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 8'hA8, 1, 8'hB5, 0);
            chk("stall", fo(1, 1, 1, 0, 0, 8'hB5));
        end
        for (int i = 5; i < 8; i++) begin
            step(1, 1, 8'hA8, 1, 8'(8'hB0 + i), 1);
            chk("resume", fo(1, 1, 1, 0, 1, 8'(8'hB0 + i)));
        end
        step(1, 1, 8'hA8, 1, 8'hB8, 1);
        chk("stall_cnt_held", fo(0, 1, 1, 1, 0, 8'hA8));
        // requester 0 drops after two beats
        step(1, 1, 8'hA9, 1, 8'hB8, 1);
        chk("drop_beat2", fo(0, 1, 1, 1, 0, 8'hA9));
        step(1, 0, 8'h00, 1, 8'hB8, 1);
        chk("drop_cycle", fo(0, 1, 0, 1, 0, 8'h00));
        step(1, 0, 8'h00, 1, 8'hB8, 1);
        chk("drop_gnt1", fo(1, 1, 1, 0, 1, 8'hB8));
        step(1, 0, 8'h00, 1, 8'hB9, 1);
        chk("gnt1_b9", fo(1, 1, 1, 0, 1, 8'hB9));
        // both go idle, then a simultaneous request goes to requester 0
        step(1, 0, 8'h00, 0, 8'h00, 1);
        chk("gnt1_drain", fo(1, 1, 0, 0, 1, 8'h00));
        step(1, 0, 8'h00, 0, 8'h00, 1);
        chk("idle_busy", fo(0, 0, 0, 0, 0, 8'h00));
        step(1, 1, 8'hAA, 1, 8'hBA, 1);
        chk("tie_idle", fo(0, 0, 0, 0, 0, 8'hAA));
        step(1, 1, 8'hAA, 1, 8'hBA, 1);
        chk("tie_to_0", fo(0, 1, 1, 1, 0, 8'hAA));
        // reset in the middle of a GNT1 burst
        for (int i = 11; i < 14; i++) begin
            step(1, 1, 8'(8'hA0 + i), 1, 8'hBA, 1);
            chk("pre_burst0", fo(0, 1, 1, 1, 0, 8'(8'hA0 + i)));
        end
        step(1, 1, 8'hAE, 1, 8'hBA, 1);
        chk("pre_gnt1", fo(1, 1, 1, 0, 1, 8'hBA));
        step(0, 1, 8'hAE, 1, 8'hBB, 1);
        chk("pre_rst", fo(1, 1, 1, 0, 1, 8'hBB));
        step(1, 1, 8'hAE, 1, 8'hBC, 1);
        chk("post_rst", fo(0, 0, 0, 0, 0, 8'hAE));
        step(1, 1, 8'hAE, 1, 8'hBC, 1);
        chk("rst_tie0", fo(0, 1, 1, 1, 0, 8'hAE));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 data mux (din_0/din_1 -> out, selected by sel) between two valid/ready requesters.
- Drives the mux select from a registered grant FSM and gates the per-requester ready signals.
- Caps consecutive beats per requester so neither source can starve the other.
- Sits between two producer channels and a single downstream consumer channel.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- MAX_BURST, 4, maximum consecutive beats granted to one requester while the other has valid asserted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  synchronous reset, active low
- din0_valid  input  1  requester 0 has a beat
- din0_data  input  WIDTH  requester 0 data
- din0_ready  output  1  requester 0 beat accepted this cycle when high with din0_valid
- din1_valid  input  1  requester 1 has a beat
- din1_data  input  WIDTH  requester 1 data
- din1_ready  output  1  requester 1 beat accepted this cycle when high with din1_valid
- out_valid  output  1  output beat valid
- out_data  output  WIDTH  muxed data
- out_ready  input  1  downstream accepts beat
- sel  output  1  mux select, 0 = requester 0, 1 = requester 1
- busy  output  1  high in either grant state

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous, active low. rst_n sampled low at a clk rising edge forces reset state.
  - Reset state: FSM = IDLE, last = 1 (requester 0 wins the first tie), beat_cnt = 0.
  - Outputs in reset: sel = 0, busy = 0, out_valid = 0, din0_ready = 0, din1_ready = 0. out_data follows din0_data.
- FSM states: IDLE, GNT0, GNT1. All state is registered.
- Derived outputs:
  - sel = 1 only in GNT1.
  - busy = (state != IDLE).
- Datapath, combinational from state:
  - out_data = sel ? din1_data : din0_data.
  - In GNTx: out_valid = dinx_valid and dinx_ready = out_ready. The non-granted ready is 0.
  - In IDLE: out_valid = 0 and both readies = 0.
- A beat completes when out_valid & out_ready.
- IDLE transitions (1-cycle arbitration latency, no beat transfers in IDLE):
  - Only din0_valid -> GNT0.
  - Only din1_valid -> GNT1.
  - Both valid -> GNT(!last), i.e. the requester not served last.
  - Neither -> stay in IDLE.
- Grant entry: on every entry to GNTx, last <= x and beat_cnt <= 0.
- GNTx transitions, evaluated each cycle:
  - dinx_valid = 0: if diny_valid (other requester) -> GNTy, else -> IDLE. No beat this cycle.
  - Beat completes and beat_cnt+1 == MAX_BURST and diny_valid -> GNTy (switch on the next cycle, no dead cycle).
  - Beat completes otherwise: stay in GNTx. beat_cnt <= min(beat_cnt+1, MAX_BURST), saturating.
  - No beat (out_ready = 0): stay in GNTx, hold beat_cnt. Grant is never revoked mid-stall.
  - Saturated beat_cnt == MAX_BURST with diny_valid newly asserted: the next completed beat switches to GNTy.
- Switching between GNT0 and GNT1 directly is allowed and costs no idle cycle.
- Protocol rule for sources: once valid is asserted it is held with stable data until ready. The arbiter does not check this.
- Reset mid-operation (rst_n low while in GNTx): the next edge enters IDLE with last = 1. Any unaccepted beat remains owned by its source.
- beat_cnt width: 8 bits.

Test Plan:
1. Reset, then din0_valid = 1, din1_valid = 0, out_ready = 1, din0_data = 0x11..0x16 over 6 beats:
   - GNT0 one cycle after valid, sel = 0 throughout.
   - Outputs 0x11..0x16 on consecutive cycles; no switch and no starvation check triggered.
2. Both valid from reset, out_ready = 1, MAX_BURST = 4, din0 stream 0xA0.., din1 stream 0xB0..:
   - Output sequence A0 A1 A2 A3 B0 B1 B2 B3 A4 ...
   - sel toggles every 4 beats; first grant goes to requester 0.
3. Stall: in GNT1 with out_ready = 0 for 5 cycles while din0_valid = 1:
   - sel stays 1, din1_ready = 0, out_data holds din1_data, beat_cnt unchanged.
   - Burst resumes when out_ready returns.
4. Requester drop: in GNT0, din0_valid drops after 2 beats while din1_valid = 1:
   - Next cycle GNT1, sel = 1; a later tie is awarded to requester 0.
5. Both sources go idle after a GNT1 burst:
   - FSM goes to IDLE, busy = 0.
   - Then din0_valid and din1_valid assert in the same cycle -> GNT0 is granted next, because last = 1.
6. rst_n = 0 for one cycle during the middle of a GNT1 burst:
   - Next cycle: sel = 0, busy = 0, out_valid = 0.
   - With both requesters valid, the first grant after reset is GNT0.
